// File: rtl/clarke_park_pkg.sv
// Shared FOC definitions: fixed-point widths, default constants, FSM encoding
// and the round/saturate helpers used by the Clarke/Park stage.
package clarke_park_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SUM_W  = 18;
  localparam int unsigned COEF_W = 16;
  localparam int unsigned PROD_W = SUM_W + COEF_W;
  localparam int unsigned ACC_W  = 35;

  localparam int          K_INV_SQRT3_DEF = 9459;
  localparam int unsigned FRAC_DEF        = 14;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BETA,
    S_D0,
    S_D1,
    S_Q0,
    S_Q1,
    S_DONE
  } cp_state_e;

  // Round half up: add half an LSB of the result, then arithmetic shift.
  function automatic logic signed [ACC_W-1:0] rnd(input logic signed [ACC_W-1:0] x,
                                                  input int unsigned frac);
    logic signed [ACC_W-1:0] half;
    half = ACC_W'(1) << (frac - 1);
    return (x + half) >>> frac;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] x);
    if (x > SAT_MAX) return DATA_W'(SAT_MAX);
    if (x < SAT_MIN) return DATA_W'(SAT_MIN);
    return DATA_W'(x);
  endfunction

endpackage

// File: rtl/foc_mul.sv
// Registered signed 18x16 multiplier shared by every arithmetic step.
module foc_mul
  import clarke_park_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [SUM_W-1:0]  a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [PROD_W-1:0] p
);

  logic signed [PROD_W-1:0] p_q, p_d;

  always_comb begin
    p_d = PROD_W'(a) * PROD_W'(b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= '0;
    else        p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: rtl/clarke_park.sv
// Clarke + Park transform: (Ia, Ib, sin, cos) -> (Id, Iq) with one shared
// multiplier, fixed six-cycle latency from accepted start pulse to done.
module clarke_park
  import clarke_park_pkg::*;
#(
  parameter int          K_INV_SQRT3 = K_INV_SQRT3_DEF,
  parameter int unsigned FRAC        = FRAC_DEF
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic                     iEn,
  input  logic signed [DATA_W-1:0] iIa,
  input  logic signed [DATA_W-1:0] iIb,
  input  logic signed [DATA_W-1:0] iSin,
  input  logic signed [DATA_W-1:0] iCos,
  output logic signed [DATA_W-1:0] oId,
  output logic signed [DATA_W-1:0] oIq,
  output logic                     oBusy,
  output logic                     oDone
);

  cp_state_e                 state_q, state_d;
  logic signed [DATA_W-1:0]  ia_q, ia_d, sin_q, sin_d, cos_q, cos_d;
  logic signed [DATA_W-1:0]  ibeta_q, ibeta_d, id_q, id_d;
  logic signed [DATA_W-1:0]  id_out_q, id_out_d, iq_out_q, iq_out_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      busy_q, busy_d, done_q, done_d;

  logic signed [SUM_W-1:0]   mul_a;
  logic signed [COEF_W-1:0]  mul_b;
  logic signed [PROD_W-1:0]  mul_p;

  foc_mul u_mul (
    .clk   (iClk),
    .rst_n (iRst_n),
    .a     (mul_a),
    .b     (mul_b),
    .p     (mul_p)
  );

  // Operands are issued one state ahead so each product lands in the state that consumes it.
  always_comb begin
    state_d  = state_q;
    ia_d     = ia_q;
    sin_d    = sin_q;
    cos_d    = cos_q;
    ibeta_d  = ibeta_q;
    id_d     = id_q;
    acc_d    = acc_q;
    id_out_d = id_out_q;
    iq_out_d = iq_out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mul_a    = '0;
    mul_b    = '0;
    case (state_q)
      S_IDLE: begin
        if (iEn) begin
          ia_d    = iIa;
          sin_d   = iSin;
          cos_d   = iCos;
          busy_d  = 1'b1;
          state_d = S_BETA;
          mul_a   = SUM_W'(iIa) + (SUM_W'(iIb) <<< 1);
          mul_b   = COEF_W'(K_INV_SQRT3);
        end
      end
      S_BETA: begin
        ibeta_d = sat16(rnd(ACC_W'(mul_p), FRAC));
        mul_a   = SUM_W'(ia_q);
        mul_b   = cos_q;
        state_d = S_D0;
      end
      S_D0: begin
        acc_d   = ACC_W'(mul_p);
        mul_a   = SUM_W'(ibeta_q);
        mul_b   = sin_q;
        state_d = S_D1;
      end
      S_D1: begin
        acc_d   = acc_q + ACC_W'(mul_p);
        mul_a   = SUM_W'(ia_q);
        mul_b   = sin_q;
        state_d = S_Q0;
      end
      S_Q0: begin
        id_d    = sat16(rnd(acc_q, FRAC));
        acc_d   = -ACC_W'(mul_p);
        mul_a   = SUM_W'(ibeta_q);
        mul_b   = cos_q;
        state_d = S_Q1;
      end
      S_Q1: begin
        id_out_d = id_q;
        iq_out_d = sat16(rnd(acc_q + ACC_W'(mul_p), FRAC));
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= S_IDLE;
      ia_q     <= '0;
      sin_q    <= '0;
      cos_q    <= '0;
      ibeta_q  <= '0;
      id_q     <= '0;
      acc_q    <= '0;
      id_out_q <= '0;
      iq_out_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ia_q     <= ia_d;
      sin_q    <= sin_d;
      cos_q    <= cos_d;
      ibeta_q  <= ibeta_d;
      id_q     <= id_d;
      acc_q    <= acc_d;
      id_out_q <= id_out_d;
      iq_out_q <= iq_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign oId   = id_out_q;
  assign oIq   = iq_out_q;
  assign oBusy = busy_q;
  assign oDone = done_q;

endmodule
